// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock with a fixed WIDTH/DIGIT-cycle latency.
// The operand-A shift register also collects the partial sum as A's bits are consumed.

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] accA_q, accA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] digitSum;
  logic             digitCarry;
  logic             topCarryIn;
  logic [WIDTH-1:0] accShifted;

  // Ripple across one digit; topCarryIn is the carry entering the digit's top bit,
  // which on the final digit is the carry into the MSB used for overflow.
  always_comb begin
    digitSum   = '0;
    digitCarry = carry_q;
    topCarryIn = carry_q;
    for (int i = 0; i < DIGIT; i++) begin
      topCarryIn  = digitCarry;
      digitSum[i] = accA_q[i] ^ opB_q[i] ^ digitCarry;
      digitCarry  = (accA_q[i] & opB_q[i]) | (digitCarry & (accA_q[i] ^ opB_q[i]));
    end
  end

  generate
    if (DIGIT == WIDTH) begin : gFullDigit
      assign accShifted = digitSum;
    end else begin : gPartDigit
      assign accShifted = {digitSum, accA_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    accA_d  = accA_q;
    opB_d   = opB_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          accA_d  = A;
          opB_d   = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        accA_d  = accShifted;
        opB_d   = opB_q >> DIGIT;
        carry_d = digitCarry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          sum_d   = accShifted;
          cout_d  = digitCarry;
          ovf_d   = topCarryIn ^ digitCarry;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      accA_q  <= '0;
      opB_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      accA_q  <= accA_d;
      opB_q   <= opB_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder in three configurations: 8x1, 1x1 and 8x4 bits/digit.
// Stimulus pushes hand-computed results; per-DUT monitors pop them whenever done pulses.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks  = 0;
  int nFails   = 0;
  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  logic       rst8, start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, s8;
  logic       rst1, start1, a1, b1, cin1, busy1, done1, s1, cout1, ovf1;
  logic       rst4, start4, cin4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, s4;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u8 (
    .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .Ovf(ovf8));

  serial_adder #(.WIDTH(1), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .Ovf(ovf1));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u4 (
    .clk(clk), .rst(rst4), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .Ovf(ovf4));

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t q4[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon8
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) checkOutput("u8 done with empty scoreboard", 32'(done8), 32'd0);
      else begin
        e = q8.pop_front();
        checkOutput("u8 S", 32'(s8), 32'(e.s));
        checkOutput("u8 Cout", 32'(cout8), 32'(e.cout));
        checkOutput("u8 Ovf", 32'(ovf8), 32'(e.ovf));
        checkOutput("u8 done cycle", 32'(cycleCnt), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) checkOutput("u1 done with empty scoreboard", 32'(done1), 32'd0);
      else begin
        e = q1.pop_front();
        checkOutput("u1 S", 32'(s1), 32'(e.s));
        checkOutput("u1 Cout", 32'(cout1), 32'(e.cout));
        checkOutput("u1 Ovf", 32'(ovf1), 32'(e.ovf));
        checkOutput("u1 done cycle", 32'(cycleCnt), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) checkOutput("u4 done with empty scoreboard", 32'(done4), 32'd0);
      else begin
        e = q4.pop_front();
        checkOutput("u4 S", 32'(s4), 32'(e.s));
        checkOutput("u4 Cout", 32'(cout4), 32'(e.cout));
        checkOutput("u4 Ovf", 32'(ovf4), 32'(e.ovf));
        checkOutput("u4 done cycle", 32'(cycleCnt), 32'(e.cyc));
      end
    end
  end

  // Each applyStimulus leaves the caller in the first RUN cycle (start already dropped).
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo; e.cyc = cycleCnt + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic applyStimulus1(input logic a, input logic b, input logic c,
                                input logic es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    e.s = 8'(es); e.cout = ec; e.ovf = eo; e.cyc = cycleCnt + 1 + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic applyStimulus4(input logic [7:0] a, input logic [7:0] b, input logic c,
                                input logic [7:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    e.s = es; e.cout = ec; e.ovf = eo; e.cyc = cycleCnt + 1 + 2;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic runCase8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo);
    applyStimulus8(a, b, c, es, ec, eo);
    repeat (9) @(negedge clk);
  endtask

  logic [7:0] sTab, cTab, oTab;
  logic [7:0] contA [9];
  logic [7:0] contB [9];
  logic       contC [9];
  logic [7:0] contS [9];
  logic       contCo [9];
  logic       contOv [9];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, cycle %0d", cycleCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    sTab = 8'b1001_0110;
    cTab = 8'b1110_1000;
    oTab = 8'b0100_0010;
    contA  = '{8'h10, 8'hAA, 8'h01, 8'h70, 8'h5C, 8'h03, 8'hFF, 8'h21, 8'h99};
    contB  = '{8'h20, 8'h11, 8'h7E, 8'h70, 8'h0A, 8'hC4, 8'hFF, 8'h42, 8'h08};
    contC  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    contS  = '{8'h30, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    contCo = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    contOv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    rst8 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
    checkOutput("u8 reset busy", 32'(busy8), 32'd0);
    checkOutput("u8 reset done", 32'(done8), 32'd0);
    checkOutput("u8 reset S", 32'(s8), 32'd0);
    checkOutput("u8 reset Cout", 32'(cout8), 32'd0);
    checkOutput("u8 reset Ovf", 32'(ovf8), 32'd0);
    checkOutput("u1 reset busy", 32'(busy1), 32'd0);
    checkOutput("u1 reset S", 32'(s1), 32'd0);
    checkOutput("u4 reset busy", 32'(busy4), 32'd0);
    checkOutput("u4 reset S", 32'(s4), 32'd0);

    runCase8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    runCase8(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);

    // Operands change mid-run; result and held outputs must not notice.
    applyStimulus8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    checkOutput("u8 busy in RUN", 32'(busy8), 32'd1);
    checkOutput("u8 S held in RUN", 32'(s8), 32'h47);
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
    repeat (9) @(negedge clk);

    runCase8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    runCase8(8'h55, 8'h22, 1'b0, 8'h77, 1'b0, 1'b0);

    // Abandon an addition in its 4th RUN cycle; no done pulse may follow.
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("u8 busy before abort", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    checkOutput("u8 busy after abort", 32'(busy8), 32'd0);
    checkOutput("u8 done after abort", 32'(done8), 32'd0);
    checkOutput("u8 S after abort", 32'(s8), 32'd0);
    checkOutput("u8 Cout after abort", 32'(cout8), 32'd0);
    repeat (12) @(negedge clk);
    runCase8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus1(i[2], i[1], i[0], sTab[i], cTab[i], oTab[i]);
      repeat (2) @(negedge clk);
    end

    // Start pulsed during RUN with different operands must be ignored.
    applyStimulus4(8'h0F, 8'hF1, 1'b1, 8'h01, 1'b1, 1'b0);
    a4 = 8'h33; b4 = 8'h44; cin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (4) @(negedge clk);

    // Start held high: accepted every N+1 = 3 cycles, operands change every cycle.
    for (int j = 0; j < 9; j++) begin
      exp_t e;
      @(negedge clk);
      start4 = 1'b1; a4 = contA[j]; b4 = contB[j]; cin4 = contC[j];
      if (j % 3 == 0) begin
        e.s = contS[j]; e.cout = contCo[j]; e.ovf = contOv[j]; e.cyc = cycleCnt + 1 + 2;
        q4.push_back(e);
      end
    end
    @(negedge clk);
    start4 = 1'b0;
    repeat (5) @(negedge clk);

    checkOutput("u8 results outstanding", 32'(q8.size()), 32'd0);
    checkOutput("u1 results outstanding", 32'(q1.size()), 32'd0);
    checkOutput("u4 results outstanding", 32'(q4.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and sum width in bits (>=1).
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning bits added per clock cycle (1..WIDTH, WIDTH divisible by DIGIT).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE or DONE.
REQ-006 The block SHALL have port A  input  WIDTH  first operand, captured on accepted start.
REQ-007 The block SHALL have port B  input  WIDTH  second operand, captured on accepted start.
REQ-008 The block SHALL have port Cin  input  1  carry-in, captured on accepted start.
REQ-009 The block SHALL have port busy  output  1  high while an addition is in progress (RUN).
REQ-010 The block SHALL have port done  output  1  one-cycle pulse: result outputs updated this cycle.
REQ-011 The block SHALL have port S  output  WIDTH  registered sum of the last completed addition.
REQ-012 The block SHALL have port Cout  output  1  registered carry-out of the last completed addition.
REQ-013 The block SHALL have port Ovf  output  1  registered two's-complement overflow (carry into MSB XOR Cout) of the last completed addition.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 On an edge in IDLE or DONE with start=1, the block SHALL capture A, B, Cin into internal shift registers, clear the digit counter, and enter RUN.
REQ-016 On an edge in IDLE with start=0, the block SHALL remain in IDLE; on an edge in DONE with start=0, it SHALL enter IDLE.
REQ-017 Each RUN edge SHALL add the DIGIT least-significant operand bits plus the running carry, shift the DIGIT sum bits into the internal sum register, shift the operands right by DIGIT, and update the running carry.
REQ-018 After N = WIDTH/DIGIT RUN edges, the block SHALL load S, Cout, Ovf from the internal result and enter DONE on that same edge.
REQ-019 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle following edge k+N, independent of operand values.
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are registered state decodes with no combinational path from inputs.
REQ-021 start while in RUN SHALL be ignored, and A/B/Cin changes during RUN SHALL NOT affect the result.
REQ-022 S, Cout, Ovf SHALL hold their previous values throughout RUN and IDLE, changing only on the completing edge.
REQ-023 start asserted during the DONE cycle SHALL be accepted (back-to-back operation, no IDLE gap).
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; {Cout,S} SHALL equal A+B+Cin exactly.
REQ-025 For WIDTH=1, Ovf SHALL equal Cin XOR Cout of the single bit position.

Reset
REQ-026 When rst=1 at an edge, the block SHALL enter IDLE and set busy=0, done=0, S=0, Cout=0, Ovf=0, regardless of state.
REQ-027 rst SHALL take priority over start; an addition in progress when rst is asserted SHALL be abandoned with no done pulse.

Verification
REQ-028 The bench SHALL cover: WIDTH=8, DIGIT=1, A=0xFF, B=0x01, Cin=0 -> done exactly 8 cycles after start edge, S=0x00, Cout=1, Ovf=0.
REQ-029 The bench SHALL cover: WIDTH=8, DIGIT=1, A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0, Ovf=1; then A=0x80, B=0x80 -> S=0x00, Cout=1, Ovf=1.
REQ-030 The bench SHALL cover: WIDTH=1, all 8 combinations of A,B,Cin stepped in order -> S,Cout match the full-adder truth table, done 1 cycle after each start.
REQ-031 The bench SHALL cover: WIDTH=8, DIGIT=4, A=0x0F, B=0xF1, Cin=1 -> done 2 cycles after start, S=0x01, Cout=1; start pulsed mid-RUN with other operands -> ignored, result unchanged.
REQ-032 The bench SHALL cover: rst asserted in 4th RUN cycle -> next cycle busy=0, done=0, S=0, no done pulse afterwards; new start then completes normally.
REQ-033 The bench SHALL cover: start held high continuously -> done pulses every N+1 cycles, each with the correct sum for operands present at its start edge.
